uart_receiver: RTL

- Serial-to-parallel UART receiver, 8N1 by default, LSB first, idle-high line.
- Counterpart to the team's uart_transmitter: decodes frames on the `rx` pin into a parallel word.
- Flags each completed frame with a one-cycle `valid` pulse, or a one-cycle `frame_error` pulse when the stop bit is bad.
- Sits at the chip boundary; `rx` is asynchronous to `clock`.

---
 rtl/uart_receiver.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel UART receiver (8N1 by default, LSB first, idle-high line).
// The asynchronous rx pin is brought into the clock domain through a two-flop
// synchronizer. A four-state FSM then finds the start bit, samples each data
// bit at its centre and checks the stop bit. Every completed frame ends in a
// one-cycle valid pulse (good stop bit) or a one-cycle frame_error pulse (bad
// stop bit, frame discarded).
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per bit period (>= 4)
//   DATA_BITS    - data bits per frame (5..9)
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   rx          in   serial line, asynchronous to clock, idle = 1
//   data        out  last correctly received word, bit 0 = first bit on line
//   valid       out  one-cycle pulse, data was just updated with a good frame
//   frame_error out  one-cycle pulse, stop bit sampled low, frame dropped
//   busy        out  high while a frame is being received
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // The counter holds j-1 just before the j-th edge after a restart, so a
  // sample lands on the edge where it reaches (distance - 1).
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 busy_q, busy_d;

  logic rx_s;
  logic sample_s;

  assign rx_s = sync2_q;

  // Start bit is sampled half a bit in; later samples are a full bit apart,
  // which keeps every sample at the centre of its bit.
  assign sample_s = ((state_q == S_START) && (cnt_q == HALF_LAST)) ||
                    (((state_q == S_DATA) || (state_q == S_STOP)) &&
                     (cnt_q == BIT_LAST));

  // State register: all flops, asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic: synchronizer, FSM transitions, counters, shift register.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (sample_s) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_START;
        end
      end

      S_DATA: begin
        if (sample_s) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_STOP: begin
        if (sample_s) begin
          // Leave at mid stop bit so a start bit right after a single stop
          // bit is still caught.
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: registered data / valid / frame_error / busy.
  always_comb begin
    data_d        = data_q;
    valid_d       = 1'b0;
    frame_error_d = 1'b0;
    busy_d        = (state_d != S_IDLE);

    if ((state_q == S_STOP) && sample_s) begin
      if (rx_s) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        frame_error_d = 1'b1;
      end
    end else begin
      data_d = data_q;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule
